// File: rtl/acc_stream_pkg.sv
// Shared constants for the accumulator stream master: FSM state codes,
// default geometry and the watchdog counter sizing helper.
package acc_stream_pkg;

  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_W       = 8;

  // State codes kept as plain constants so older tools see a simple vector.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DEF_WDW = wd_width(DEF_TIMEOUT);

endpackage

// File: rtl/acc_stream_gen.sv
// Byte generator: seed + i*step sequence with a running modular sum and a
// last-byte flag, advanced one byte per accepted transfer.
module acc_stream_gen
  import acc_stream_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         adv,
  input  logic [W-1:0] job_len,
  input  logic [W-1:0] job_seed,
  input  logic [W-1:0] job_step,
  output logic [W-1:0] len,
  output logic [W-1:0] data,
  output logic [W-1:0] sum,
  output logic         last
);

  logic [W-1:0] step_q;
  logic [W-1:0] idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      len    <= '0;
      data   <= '0;
      sum    <= '0;
      step_q <= '0;
      idx    <= '0;
    end else if (load) begin
      len    <= job_len;
      data   <= job_seed;
      sum    <= '0;
      step_q <= job_step;
      idx    <= '0;
    end else if (adv) begin
      data <= data + step_q;
      sum  <= sum + data;
      idx  <= idx + W'(1);
    end
  end

  assign last = (idx == len - W'(1));

endmodule

// File: rtl/acc_stream_master.sv
// Streams a generated byte sequence into an accumulator (len, din, dout
// methods) and compares its result with a locally computed sum.
//   state  | meaning
//   IDLE   | waiting for job_en
//   LEN    | writing the byte count
//   DATA   | streaming bytes, one per accepted din transfer
//   RESULT | reading the accumulated value
//   DONE   | one-cycle result pulse
module acc_stream_master
  import acc_stream_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int W       = DEF_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] job_len,
  input  logic [W-1:0] job_seed,
  input  logic [W-1:0] job_step,
  input  logic         job_en,
  output logic         job_rdy,
  output logic [W-1:0] len_data,
  output logic         len_en,
  input  logic         len_rdy,
  output logic [W-1:0] din_data,
  output logic         din_en,
  input  logic         din_rdy,
  input  logic [W-1:0] dout_data,
  output logic         dout_en,
  input  logic         dout_rdy,
  output logic         res_valid,
  output logic [W-1:0] res_sum,
  output logic [W-1:0] res_exp,
  output logic         res_match,
  output logic         res_timeout,
  output logic         busy
);

  localparam int WDW = wd_width(TIMEOUT);

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic [WDW-1:0] wd;
  logic           wd_expired;
  logic           abort_nx;
  logic           xfer;
  logic [W-1:0]   gen_len;
  logic [W-1:0]   gen_sum;
  logic           gen_last;

  acc_stream_gen #(.W(W)) u_gen (
    .CLK      (CLK),
    .RST      (RST),
    .load     (job_rdy && job_en),
    .adv      (din_en),
    .job_len  (job_len),
    .job_seed (job_seed),
    .job_step (job_step),
    .len      (gen_len),
    .data     (din_data),
    .sum      (gen_sum),
    .last     (gen_last)
  );

  // Enables are gated by ready so an enable always means a transfer.
  assign job_rdy    = (state == ST_IDLE);
  assign busy       = ~job_rdy;
  assign len_en     = (state == ST_LEN) && len_rdy;
  assign din_en     = (state == ST_DATA) && din_rdy;
  assign dout_en    = (state == ST_RESULT) && dout_rdy;
  assign res_valid  = (state == ST_DONE);
  assign len_data   = gen_len;
  assign xfer       = len_en || din_en || dout_en;
  assign wd_expired = (wd == WDW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    abort_nx = 1'b0;
    case (state)
      ST_IDLE:   if (job_en) state_nx = ST_LEN;
      ST_LEN:    if (len_en) state_nx = (gen_len == '0) ? ST_RESULT : ST_DATA;
                 else if (wd_expired) begin state_nx = ST_DONE; abort_nx = 1'b1; end
      ST_DATA:   if (din_en) begin if (gen_last) state_nx = ST_RESULT; end
                 else if (wd_expired) begin state_nx = ST_DONE; abort_nx = 1'b1; end
      ST_RESULT: if (dout_en) state_nx = ST_DONE;
                 else if (wd_expired) begin state_nx = ST_DONE; abort_nx = 1'b1; end
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      wd          <= '0;
      res_sum     <= '0;
      res_exp     <= '0;
      res_match   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer || state_nx != state)
        wd <= '0;
      else if (state == ST_LEN || state == ST_DATA || state == ST_RESULT)
        wd <= wd + WDW'(1);
      // Result registers only move on the way into DONE; on abort the last
      // captured accumulator value is left in res_sum.
      if (state != ST_DONE && state_nx == ST_DONE) begin
        res_exp     <= gen_sum;
        res_timeout <= abort_nx;
        res_match   <= !abort_nx && (dout_data == gen_sum);
        if (!abort_nx) res_sum <= dout_data;
      end
    end
  end

endmodule

// File: tb/tb_acc_stream_master.sv
// Randomised bench for acc_stream_master against a list-based reference of
// the byte sequence and its modular sum.
module tb_acc_stream_master;
  import acc_stream_pkg::*;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] job_len, job_seed, job_step, len_data, din_data, dout_data, res_sum, res_exp;
  logic       job_en, job_rdy, len_en, len_rdy, din_en, din_rdy, dout_en, dout_rdy;
  logic       res_valid, res_match, res_timeout, busy;
  int         nchk = 0;
  int         nfail = 0;

  always #5 CLK = ~CLK;

  acc_stream_master #(.TIMEOUT(TO), .W(8)) dut (
    .CLK(CLK), .RST(RST),
    .job_len(job_len), .job_seed(job_seed), .job_step(job_step),
    .job_en(job_en), .job_rdy(job_rdy),
    .len_data(len_data), .len_en(len_en), .len_rdy(len_rdy),
    .din_data(din_data), .din_en(din_en), .din_rdy(din_rdy),
    .dout_data(dout_data), .dout_en(dout_en), .dout_rdy(dout_rdy),
    .res_valid(res_valid), .res_sum(res_sum), .res_exp(res_exp),
    .res_match(res_match), .res_timeout(res_timeout), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode 0: all ready; 1: din_rdy toggles; 2: random readies plus stray job_en
  task automatic run_job(input string nm, input int len, input int seed, input int step,
                         input int mode, input bit stall, input bit bad);
    int exp_b[$];
    int got_b[$];
    int exp_sum = 0;
    int dval, cyc = 0, last_x = -1, len_cnt = 0, len_val = -1;
    int v_cnt = 0, v_cyc = -1, first_din = -1, last_din = -1;
    int r_sum = 0, r_exp = 0, r_match = 0, r_to = 0;
    bit tog = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_b.push_back((seed + i * step) % 256);
      exp_sum = (exp_sum + exp_b[i]) % 256;
    end
    dval = bad ? (exp_sum + 255) % 256 : exp_sum;
    @(negedge CLK);
    chk({nm, "/job_rdy"}, int'(job_rdy), 1);
    job_len = len[7:0]; job_seed = seed[7:0]; job_step = step[7:0]; job_en = 1'b1;
    @(negedge CLK);
    job_en = 1'b0;
    dout_data = dval[7:0];
    while (cyc < 300) begin
      if (res_valid) begin
        v_cnt++; v_cyc = cyc;
        r_sum = res_sum; r_exp = res_exp; r_match = res_match; r_to = res_timeout;
      end
      if (v_cyc >= 0 && cyc == v_cyc + 1) begin
        job_en = 1'b0;
        chk({nm, "/idle_rdy"}, int'(job_rdy), 1);
        chk({nm, "/idle_valid"}, int'(res_valid), 0);
        chk({nm, "/hold_exp"}, int'(res_exp), exp_sum);
        break;
      end
      case (mode)
        0: begin len_rdy = 1'b1; din_rdy = 1'b1; dout_rdy = !stall; end
        1: begin len_rdy = 1'b1; din_rdy = tog; tog = !tog; dout_rdy = !stall; end
        default: begin
          len_rdy  = ($urandom_range(3) != 0);
          din_rdy  = ($urandom_range(3) != 0);
          dout_rdy = !stall && ($urandom_range(3) != 0);
        end
      endcase
      job_en = (mode == 2 && busy) ? 1'($urandom_range(1)) : 1'b0;
      if (job_en) begin job_len = 8'($urandom); job_seed = 8'($urandom); job_step = 8'($urandom); end
      #1;
      if (len_en) begin len_cnt++; len_val = len_data; last_x = cyc; end
      if (din_en) begin
        got_b.push_back(din_data);
        if (first_din < 0) first_din = cyc;
        last_din = cyc; last_x = cyc;
      end
      @(negedge CLK);
      cyc++;
    end
    job_en = 1'b0;
    chk({nm, "/finished"}, int'(v_cyc >= 0), 1);
    chk({nm, "/len_writes"}, len_cnt, 1);
    chk({nm, "/len_data"}, len_val, len);
    chk({nm, "/din_count"}, got_b.size(), len);
    for (int i = 0; i < len && i < got_b.size(); i++)
      chk($sformatf("%s/byte%0d", nm, i), got_b[i], exp_b[i]);
    if (mode == 0 && len > 0) begin
      chk({nm, "/first_din_cyc"}, first_din, 1);
      chk({nm, "/last_din_cyc"}, last_din, len);
    end
    chk({nm, "/valid_pulses"}, v_cnt, 1);
    chk({nm, "/res_exp"}, r_exp, exp_sum);
    chk({nm, "/res_timeout"}, r_to, int'(stall));
    chk({nm, "/res_match"}, r_match, int'(!stall && !bad));
    if (!stall) chk({nm, "/res_sum"}, r_sum, dval);
    else chk({nm, "/timeout_cyc"}, v_cyc, last_x + 1 + TO);
  endtask

  initial begin
    int n;
    RST = 1'b1; job_en = 1'b0; job_len = '0; job_seed = '0; job_step = '0;
    len_rdy = 1'b1; din_rdy = 1'b1; dout_rdy = 1'b1; dout_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst/job_rdy", int'(job_rdy), 1);
    chk("rst/busy", int'(busy), 0);
    chk("rst/ens", int'({len_en, din_en, dout_en}), 0);
    chk("rst/res_valid", int'(res_valid), 0);
    chk("rst/res_regs", int'({res_sum, res_exp, res_match, res_timeout}), 0);
    chk("rst/data", int'({len_data, din_data}), 0);
    RST = 1'b0;

    run_job("basic", 4, 1, 1, 0, 1'b0, 1'b0);
    run_job("toggle", 4, 1, 1, 1, 1'b0, 1'b0);
    run_job("wrap", 3, 200, 100, 0, 1'b0, 1'b1);
    run_job("len0", 0, 7, 9, 0, 1'b0, 1'b0);
    run_job("tmo", 2, 5, 6, 0, 1'b1, 1'b0);
    run_job("tmo_len0", 0, 1, 1, 0, 1'b1, 1'b0);

    // Reset in the middle of a 5-byte stream.
    @(negedge CLK);
    job_len = 8'd5; job_seed = 8'd10; job_step = 8'd3; job_en = 1'b1;
    len_rdy = 1'b1; din_rdy = 1'b1; dout_rdy = 1'b1;
    @(negedge CLK);
    job_en = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      #1;
      if (din_en) n++;
      @(negedge CLK);
    end
    chk("mid_rst/bytes_before", n, 2);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst/job_rdy", int'(job_rdy), 1);
    chk("mid_rst/ens", int'({len_en, din_en, dout_en}), 0);
    chk("mid_rst/res_valid", int'(res_valid), 0);
    chk("mid_rst/res_exp", int'(res_exp), 0);
    RST = 1'b0;
    run_job("after_rst", 5, 10, 3, 0, 1'b0, 1'b0);

    for (int j = 0; j < 8; j++)
      run_job($sformatf("rnd%0d", j), $urandom_range(0, 20), $urandom_range(0, 255),
              $urandom_range(0, 255), 2, 1'b0, 1'($urandom_range(1)));
    run_job("rnd_big", 255, $urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/acc_stream_master.md
ACC_STREAM_MASTER -- requirements
Module: acc_stream_master

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles waited in any handshake state before abort.
REQ-002 Parameter W, default 8: width of the len, din and dout data paths.
REQ-003 Port CLK  in  1: single clock; all state changes on rising edge.
REQ-004 Port RST  in  1: reset, synchronous, active-high.
REQ-005 Port job_len  in  W: number of bytes to stream, 0..255.
REQ-006 Port job_seed  in  W: first data byte.
REQ-007 Port job_step  in  W: increment between successive bytes.
REQ-008 Port job_en  in  1: job accept strobe; legal only while job_rdy=1.
REQ-009 Port job_rdy  out  1: block idle, can accept a job.
REQ-010 Port len_data  out  W: length value driven to the accumulator len method.
REQ-011 Port len_en  out  1: len method enable.
REQ-012 Port len_rdy  in  1: len method ready.
REQ-013 Port din_data  out  W: stream byte.
REQ-014 Port din_en  out  1: din method enable.
REQ-015 Port din_rdy  in  1: din method ready.
REQ-016 Port dout_data  in  W: accumulated result from the accumulator.
REQ-017 Port dout_en  out  1: dout actionvalue enable.
REQ-018 Port dout_rdy  in  1: dout ready.
REQ-019 Port res_valid  out  1: one-cycle pulse, job finished.
REQ-020 Port res_sum  out  W: result captured from dout_data.
REQ-021 Port res_exp  out  W: internally computed expected sum.
REQ-022 Port res_match  out  1: res_sum == res_exp, and no timeout.
REQ-023 Port res_timeout  out  1: job aborted by the watchdog.
REQ-024 Port busy  out  1: job in progress (inverse of job_rdy).

Function
REQ-025 FSM states: IDLE, LEN, DATA, RESULT, DONE.
REQ-026 Transfers on any method occur only on an edge where en=1 and rdy=1; each en is asserted only when its rdy=1 (en = state-match AND rdy, combinational).
REQ-027 IDLE: job_rdy=1; on job_en, latch len/seed/step, clear byte counter, expected sum and watchdog; go to LEN.
REQ-028 LEN: len_data = latched len; on the transfer go to DATA, or to RESULT if len=0.
REQ-029 DATA: din_data = seed + i*step mod 2^W for byte index i; each transfer adds din_data to the expected sum (mod 2^W) and increments i; after transfer of byte len-1 go to RESULT.
REQ-030 RESULT: on the dout transfer, capture dout_data into res_sum; go to DONE.
REQ-031 DONE: res_valid=1 for exactly one cycle; return to IDLE.
REQ-032 res_sum, res_exp, res_match and res_timeout hold their values until the next job's DONE.
REQ-033 Watchdog: clears on every transfer and on entry to any state; counts while in LEN/DATA/RESULT; on reaching TIMEOUT go to DONE with res_timeout=1 and res_match=0.
REQ-034 job_en while busy is ignored; no state change.
REQ-035 Throughput: one byte per cycle while din_rdy stays high; no bubble between LEN→DATA or DATA→RESULT beyond the state edge.

Reset
REQ-036 RST=1 at an edge forces IDLE from any state, including mid-DATA; the partial job is dropped with no res_valid.
REQ-037 Reset values: job_rdy=1, busy=0, all *_en=0, res_valid=0, res_sum=0, res_exp=0, res_match=0, res_timeout=0, len_data=0, din_data=0.

Structure
REQ-038 A shared package holds the FSM state enum, the default TIMEOUT and W constants, and the watchdog counter width clog2(TIMEOUT+1).
REQ-039 One sub-module, acc_stream_gen: a byte generator (seed/step/count with advance strobe, last flag, running sum); the FSM stays in the top.

Verification
REQ-040 len=4, seed=1, step=1, all rdy=1 → len_data=4, din 1,2,3,4 on 4 consecutive cycles, res_exp=10; dout_data=10 → res_match=1.
REQ-041 Same job with din_rdy toggling every cycle → same byte order, no duplicates or drops, res_exp=10.
REQ-042 len=3, seed=200, step=100 → din 200,44,144; res_exp=132 (wrap-around); dout_data=131 → res_match=0.
REQ-043 len=0 → len write of 0, no din_en, dout read, res_exp=0.
REQ-044 dout_rdy held low with TIMEOUT=16 → res_valid with res_timeout=1 exactly 16 cycles after entering RESULT.
REQ-045 RST asserted after byte 2 of 5 → next cycle IDLE, job_rdy=1, all en=0; a fresh job then completes correctly.
